// File: rtl/rastreador_pkg.sv
// Shared constants for the position tracker: state offsets,
// default token codes and the port-width helper.
package rastreador_pkg;

  localparam int OFS_ERRO  = 3;
  localparam int OFS_BAIXA = 4;
  localparam int OFS_ALTA  = 5;

  localparam int N_POS_DEF  = 5;
  localparam int CODE_W_DEF = 7;

  // Position 5 down to position 1
  localparam logic [34:0] COD_PADRAO_DEF = {
    7'b1101110,
    7'b1011010,
    7'b1111100,
    7'b1000100,
    7'b1100000
  };

  localparam logic [6:0] COD_BAIXA_DEF  = 7'b1001001;
  localparam logic [6:0] COD_ALTA_DEF   = 7'b1010011;
  localparam logic [6:0] COD_ABORTA_DEF = 7'b1110101;

  typedef enum logic [1:0] {
    CL_IDLE,
    CL_POS,
    CL_FIM
  } classe_e;

  function automatic int larg(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rastreador_posicao_tabela.sv
// Programmable code table with a priority lookup that maps
// an input token to the lowest matching position.
module tabela_codigos
  import rastreador_pkg::*;
#(
  parameter int N_POS = 5,
  parameter int CODE_W = 7,
  parameter logic [N_POS*CODE_W-1:0] COD_PADRAO = COD_PADRAO_DEF
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic                        i_prog_en,
  input  logic [larg(N_POS)-1:0]      i_prog_end,
  input  logic [CODE_W-1:0]           i_prog_cod,
  input  logic [CODE_W-1:0]           i_tok,
  output logic                        o_hit,
  output logic [larg(N_POS+6)-1:0]    o_pos
);

  localparam int SW = larg(N_POS + 6);

  logic [CODE_W-1:0] r_tab [N_POS];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_POS; k++) begin
        r_tab[k] <= COD_PADRAO[k*CODE_W +: CODE_W];
      end
    end else if (i_prog_en) begin
      // Out-of-range indices match no entry and are dropped
      for (int k = 0; k < N_POS; k++) begin
        if (int'(i_prog_end) == k) begin
          r_tab[k] <= i_prog_cod;
        end
      end
    end
  end

  // Scan downwards so the lowest matching position is the last written
  always_comb begin
    o_hit = 1'b0;
    o_pos = '0;
    for (int k = N_POS - 1; k >= 0; k--) begin
      if (i_tok == r_tab[k]) begin
        o_hit = 1'b1;
        o_pos = SW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/rastreador_posicao.sv
// Position tracker FSM: follows adjacent position tokens, counts
// moves and latches error / exit outcomes until cleared.
module rastreador_posicao
  import rastreador_pkg::*;
#(
  parameter int N_POS = 5,
  parameter int CODE_W = 7,
  parameter int MAX_PASSOS = 15,
  parameter int LIM_BAIXO = 3,
  parameter logic [N_POS*CODE_W-1:0] COD_PADRAO = COD_PADRAO_DEF,
  parameter logic [CODE_W-1:0] COD_SAIDA_BAIXA = COD_BAIXA_DEF,
  parameter logic [CODE_W-1:0] COD_SAIDA_ALTA = COD_ALTA_DEF,
  parameter logic [CODE_W-1:0] COD_ABORTA = COD_ABORTA_DEF
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic [CODE_W-1:0]        Entrada,
  input  logic                     Controle,
  input  logic                     Limpar,
  input  logic                     Prog_en,
  input  logic [larg(N_POS)-1:0]   Prog_end,
  input  logic [CODE_W-1:0]        Prog_cod,
  output logic [larg(N_POS+6)-1:0] Saida,
  output logic [7:0]               Passos,
  output logic                     Valido
);

  localparam int SW = larg(N_POS + 6);

  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_ERRO  = SW'(N_POS + OFS_ERRO);
  localparam logic [SW-1:0] S_BAIXA = SW'(N_POS + OFS_BAIXA);
  localparam logic [SW-1:0] S_ALTA  = SW'(N_POS + OFS_ALTA);
  localparam logic [7:0]    P_MAX   = 8'(MAX_PASSOS);

  logic [SW-1:0] r_est;
  logic [SW-1:0] w_est_nxt;
  logic [7:0]    r_passos;
  logic [7:0]    w_passos_nxt;
  logic          r_valido;
  logic          w_valido_nxt;

  logic          w_hit;
  logic [SW-1:0] w_pos;
  classe_e       w_classe;
  logic          w_tok;
  logic          w_vizinho;
  logic          w_satura;
  logic          w_baixo;

  tabela_codigos #(
    .N_POS      (N_POS),
    .CODE_W     (CODE_W),
    .COD_PADRAO (COD_PADRAO)
  ) u_tabela (
    .clk        (clk),
    .i_rst      (Reset),
    .i_prog_en  (Prog_en),
    .i_prog_end (Prog_end),
    .i_prog_cod (Prog_cod),
    .i_tok      (Entrada),
    .o_hit      (w_hit),
    .o_pos      (w_pos)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_est    <= S_IDLE;
      r_passos <= '0;
      r_valido <= 1'b0;
    end else begin
      r_est    <= w_est_nxt;
      r_passos <= w_passos_nxt;
      r_valido <= w_valido_nxt;
    end
  end

  always_comb begin
    w_classe = CL_FIM;
    if (r_est == S_IDLE) begin
      w_classe = CL_IDLE;
    end else if (int'(r_est) <= N_POS) begin
      w_classe = CL_POS;
    end
  end

  // Programming and clearing both block the token in the same cycle
  assign w_tok = Controle & ~Limpar & ~Prog_en;

  assign w_vizinho = w_hit &&
    ((w_pos == r_est + SW'(1)) || (w_pos == r_est - SW'(1)));

  assign w_satura = (int'(r_passos) + 1) >= MAX_PASSOS;
  assign w_baixo  = int'(r_est) <= LIM_BAIXO;

  always_comb begin
    w_est_nxt    = r_est;
    w_passos_nxt = r_passos;
    w_valido_nxt = 1'b0;
    if (Limpar) begin
      w_est_nxt    = S_IDLE;
      w_passos_nxt = '0;
    end else if (w_tok) begin
      unique case (1'b1)
        (w_classe == CL_IDLE): begin
          if (w_hit) begin
            w_est_nxt    = w_pos;
            w_valido_nxt = 1'b1;
          end
        end
        (w_classe == CL_POS): begin
          if (w_hit) begin
            if (w_vizinho) begin
              w_valido_nxt = 1'b1;
              if (w_satura) begin
                w_est_nxt    = S_ERRO;
                w_passos_nxt = P_MAX;
              end else begin
                w_est_nxt    = w_pos;
                w_passos_nxt = r_passos + 8'd1;
              end
            end else if (w_pos != r_est) begin
              w_est_nxt    = S_ERRO;
              w_valido_nxt = 1'b1;
            end
          end else if (Entrada == COD_ABORTA) begin
            w_est_nxt    = S_ERRO;
            w_valido_nxt = 1'b1;
          end else if (Entrada == COD_SAIDA_BAIXA && w_baixo) begin
            w_est_nxt    = S_BAIXA;
            w_valido_nxt = 1'b1;
          end else if (Entrada == COD_SAIDA_ALTA && !w_baixo) begin
            w_est_nxt    = S_ALTA;
            w_valido_nxt = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    Saida  = r_est;
    Passos = r_passos;
    Valido = r_valido;
  end

endmodule

// File: tb/tb_rastreador_posicao.sv
// Vector table plus scoreboard bench for the position tracker,
// with a second instance exercising move-limit saturation.
module tb_rastreador_posicao;

  logic       clk = 1'b0;
  logic       Reset;
  logic [6:0] Entrada;
  logic       Controle;
  logic       Limpar;
  logic       Prog_en;
  logic [2:0] Prog_end;
  logic [6:0] Prog_cod;

  logic [3:0] sa_a, sa_b;
  logic [7:0] pa_a, pa_b;
  logic       va_a, va_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rastreador_posicao dut_a (
    .clk      (clk),
    .Reset    (Reset),
    .Entrada  (Entrada),
    .Controle (Controle),
    .Limpar   (Limpar),
    .Prog_en  (Prog_en),
    .Prog_end (Prog_end),
    .Prog_cod (Prog_cod),
    .Saida    (sa_a),
    .Passos   (pa_a),
    .Valido   (va_a)
  );

  rastreador_posicao #(.MAX_PASSOS(3)) dut_b (
    .clk      (clk),
    .Reset    (Reset),
    .Entrada  (Entrada),
    .Controle (Controle),
    .Limpar   (Limpar),
    .Prog_en  (Prog_en),
    .Prog_end (Prog_end),
    .Prog_cod (Prog_cod),
    .Saida    (sa_b),
    .Passos   (pa_b),
    .Valido   (va_b)
  );

  typedef struct {
    logic       rst, lim, ctl, pen;
    logic [2:0] pend;
    logic [6:0] pcod, ent;
    logic [3:0] s;
    logic [7:0] p;
    logic       v;
  } vec_t;

  typedef struct {
    bit         sel;
    int         id;
    logic [3:0] s;
    logic [7:0] p;
    logic       v;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  localparam logic [6:0] P1 = 7'b1100000;
  localparam logic [6:0] P2 = 7'b1000100;
  localparam logic [6:0] P3 = 7'b1111100;
  localparam logic [6:0] P4 = 7'b1011010;
  localparam logic [6:0] P5 = 7'b1101110;
  localparam logic [6:0] SB = 7'b1001001;
  localparam logic [6:0] SA = 7'b1010011;
  localparam logic [6:0] AB = 7'b1110101;

  function automatic vec_t mk(
    input logic rst, lim, ctl, pen,
    input logic [2:0] pend,
    input logic [6:0] pcod, ent,
    input logic [3:0] s,
    input logic [7:0] p,
    input logic v
  );
    vec_t r;
    r.rst = rst; r.lim = lim; r.ctl = ctl; r.pen = pen;
    r.pend = pend; r.pcod = pcod; r.ent = ent;
    r.s = s; r.p = p; r.v = v;
    return r;
  endfunction

  function automatic vec_t tk(
    input logic [6:0] ent, input logic [3:0] s,
    input logic [7:0] p, input logic v
  );
    return mk(0, 0, 1, 0, 3'd0, 7'd0, ent, s, p, v);
  endfunction

  function automatic vec_t clr();
    return mk(0, 1, 0, 0, 3'd0, 7'd0, 7'd0, 4'd0, 8'd0, 0);
  endfunction

  function automatic vec_t rst();
    return mk(1, 0, 0, 0, 3'd0, 7'd0, 7'd0, 4'd0, 8'd0, 0);
  endfunction

  function automatic vec_t prg(
    input logic [2:0] pend, input logic [6:0] pcod,
    input logic ctl, input logic [6:0] ent,
    input logic [3:0] s, input logic [7:0] p
  );
    return mk(0, 0, ctl, 1, pend, pcod, ent, s, p, 0);
  endfunction

  task automatic confere();
    exp_t e;
    logic [3:0] s;
    logic [7:0] p;
    logic v;
    e = sb.pop_front();
    s = e.sel ? sa_b : sa_a;
    p = e.sel ? pa_b : pa_a;
    v = e.sel ? va_b : va_a;
    total += 3;
    if (s !== e.s) begin
      bad++;
      $display("FAIL v%0d.%0d saida: got %0d want %0d",
               e.sel, e.id, s, e.s);
    end
    if (p !== e.p) begin
      bad++;
      $display("FAIL v%0d.%0d passos: got %0d want %0d",
               e.sel, e.id, p, e.p);
    end
    if (v !== e.v) begin
      bad++;
      $display("FAIL v%0d.%0d valido: got %0d want %0d",
               e.sel, e.id, v, e.v);
    end
  endtask

  task automatic passo(input vec_t t, input bit sel, input int id);
    exp_t e;
    @(negedge clk);
    Reset    = t.rst;
    Limpar   = t.lim;
    Controle = t.ctl;
    Prog_en  = t.pen;
    Prog_end = t.pend;
    Prog_cod = t.pcod;
    Entrada  = t.ent;
    e.sel = sel; e.id = id; e.s = t.s; e.p = t.p; e.v = t.v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    confere();
  endtask

  initial begin
    Reset = 1'b1; Limpar = 1'b0; Controle = 1'b0;
    Prog_en = 1'b0; Prog_end = '0; Prog_cod = '0; Entrada = '0;

    // Main walk to high exit
    tbl.push_back(rst());
    tbl.push_back(tk(P1, 1, 0, 1));
    tbl.push_back(tk(P2, 2, 1, 1));
    tbl.push_back(tk(P3, 3, 2, 1));
    tbl.push_back(tk(P4, 4, 3, 1));
    tbl.push_back(tk(SA, 10, 3, 1));
    tbl.push_back(tk(P1, 10, 3, 0));
    tbl.push_back(clr());
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 7'd0, P1, 0, 0, 0));
    // Jump error, sticky
    tbl.push_back(tk(P1, 1, 0, 1));
    tbl.push_back(tk(P3, 8, 0, 1));
    tbl.push_back(tk(P2, 8, 0, 0));
    tbl.push_back(clr());
    // Low exit refused above the limit, high exit taken
    tbl.push_back(tk(P4, 4, 0, 1));
    tbl.push_back(tk(SB, 4, 0, 0));
    tbl.push_back(tk(SA, 10, 0, 1));
    tbl.push_back(clr());
    // Unknown / same-position tokens, low exit
    tbl.push_back(tk(P2, 2, 0, 1));
    tbl.push_back(tk(7'd0, 2, 0, 0));
    tbl.push_back(tk(P2, 2, 0, 0));
    tbl.push_back(tk(SA, 2, 0, 0));
    tbl.push_back(tk(SB, 9, 0, 1));
    tbl.push_back(clr());
    // Abort and top position
    tbl.push_back(tk(P5, 5, 0, 1));
    tbl.push_back(tk(AB, 8, 0, 1));
    tbl.push_back(clr());
    // Limpar beats token
    tbl.push_back(tk(P1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 3'd0, 7'd0, P2, 0, 0, 0));
    // Prog_en blocks token; write lands
    tbl.push_back(tk(P1, 1, 0, 1));
    tbl.push_back(prg(3'd1, 7'b0001111, 1, P2, 1, 0));
    tbl.push_back(tk(P2, 1, 0, 0));
    tbl.push_back(tk(7'b0001111, 2, 1, 1));
    tbl.push_back(clr());
    // Out-of-range writes discarded
    tbl.push_back(prg(3'd5, 7'b1110000, 0, 7'd0, 0, 0));
    tbl.push_back(prg(3'd7, 7'b1110001, 0, 7'd0, 0, 0));
    tbl.push_back(tk(7'b1110000, 0, 0, 0));
    tbl.push_back(tk(7'b1110001, 0, 0, 0));
    // Reprogram index 0, then reset restores defaults
    tbl.push_back(prg(3'd0, 7'b0000111, 0, 7'd0, 0, 0));
    tbl.push_back(tk(7'b0000111, 1, 0, 1));
    tbl.push_back(tk(P1, 1, 0, 0));
    tbl.push_back(rst());
    tbl.push_back(tk(P1, 1, 0, 1));
    // Reset beats everything while at position 3
    tbl.push_back(tk(P2, 2, 1, 1));
    tbl.push_back(tk(P3, 3, 2, 1));
    tbl.push_back(mk(1, 1, 1, 1, 3'd0, 7'd0, P2, 0, 0, 0));
    tbl.push_back(tk(P2, 2, 0, 1));
    tbl.push_back(tk(P1, 1, 1, 1));
    tbl.push_back(clr());
    // Duplicate entry: lowest position wins
    tbl.push_back(prg(3'd2, P1, 0, 7'd0, 0, 0));
    tbl.push_back(tk(P1, 1, 0, 1));
    tbl.push_back(tk(P4, 8, 0, 1));

    foreach (tbl[i]) passo(tbl[i], 1'b0, i);

    // Saturation on the MAX_PASSOS=3 instance
    passo(rst(), 1'b1, 0);
    passo(tk(P1, 1, 0, 1), 1'b1, 1);
    passo(tk(P2, 2, 1, 1), 1'b1, 2);
    passo(tk(P1, 1, 2, 1), 1'b1, 3);
    passo(tk(P2, 8, 3, 1), 1'b1, 4);
    passo(tk(P1, 8, 3, 0), 1'b1, 5);
    passo(clr(), 1'b1, 6);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rastreador_posicao.md
RASTREADOR_POSICAO -- requirements
Module: rastreador_posicao

Interface
REQ-001 SHALL have parameter N_POS, default 5, number of position states (2..12).
REQ-002 SHALL have parameter CODE_W, default 7, token width.
REQ-003 SHALL have parameter MAX_PASSOS, default 15, accepted-move limit before forced error (1..255).
REQ-004 SHALL have parameter LIM_BAIXO, default 3, highest position accepting the low exit code.
REQ-005 SHALL have parameter COD_PADRAO, default {1101110,1011010,1111100,1000100,1100000} (position N_POS down to 1), reset code table.
REQ-006 SHALL have parameters COD_SAIDA_BAIXA (default 1001001), COD_SAIDA_ALTA (default 1010011) and COD_ABORTA (default 1110101).
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 Entrada  input  CODE_W  token sampled when Controle=1.
REQ-010 Controle  input  1  token enable; Entrada is ignored when low.
REQ-011 Limpar  input  1  returns any state to idle without reloading the code table.
REQ-012 Prog_en  input  1  code-table write strobe.
REQ-013 Prog_end  input  clog2(N_POS)  table index; index k programs position k+1.
REQ-014 Prog_cod  input  CODE_W  code written.
REQ-015 Saida  output  clog2(N_POS+6)  registered state: 0 idle, 1..N_POS position, N_POS+3 error, N_POS+4 low exit, N_POS+5 high exit.
REQ-016 Passos  output  8  count of accepted position moves since idle.
REQ-017 Valido  output  1  one-cycle pulse on every cycle Saida changes due to a token.

Function
REQ-018 SHALL decode a token to position p when it equals table entry p-1; on duplicates, the lowest p wins.
REQ-019 From idle, a position code SHALL go to that position; every other token SHALL be ignored.
REQ-020 From position s, code for s-1 or s+1 (in 1..N_POS) SHALL move there and increment Passos.
REQ-021 From position s, a code for any other position except s, or COD_ABORTA, SHALL go to error.
REQ-022 From position s, the code for s itself SHALL be ignored.
REQ-023 COD_SAIDA_BAIXA SHALL go to low exit when s<=LIM_BAIXO and be ignored otherwise.
REQ-024 COD_SAIDA_ALTA SHALL go to high exit when s>LIM_BAIXO and be ignored otherwise.
REQ-025 Unrecognised tokens SHALL leave state, Passos and Valido unchanged.
REQ-026 A move that brings Passos to MAX_PASSOS SHALL instead go to error, with Passos saturating at MAX_PASSOS.
REQ-027 Error, low exit and high exit SHALL be sticky until Reset or Limpar.
REQ-028 Limpar SHALL set Saida=0 and Passos=0 next cycle; Valido SHALL stay 0.
REQ-029 Limpar SHALL override a same-cycle token.
REQ-030 Prog_en SHALL write the table next cycle, and a same-cycle token SHALL be ignored.
REQ-031 Prog_end>=N_POS SHALL be a discarded write.
REQ-032 Saida and Passos SHALL change one cycle after the sampling edge, with no combinational path from inputs.
REQ-033 Entry from idle SHALL not increment Passos.

Reset
REQ-034 Reset SHALL set Saida=0, Passos=0, Valido=0 and load COD_PADRAO into the table.
REQ-035 Reset SHALL take priority over Limpar, Prog_en and Controle, including mid-sequence.

Structure
REQ-036 State encoding constants, default codes and the width function SHALL live in a shared package, rastreador_pkg.
REQ-037 The code table plus token-to-position lookup SHALL be one sub-module, tabela_codigos; the FSM and counter SHALL stay in the top module.

Verification
REQ-038 Default parameters, tokens 1100000,1000100,1111100,1011010,1010011 -> Saida 1,2,3,4,10; Passos 3; Valido pulses 5 times.
REQ-039 Position 1 then 1111100 -> Saida 8 sticky; further tokens ignored; Limpar -> Saida 0.
REQ-040 Position 4 then 1001001 -> Saida 4 unchanged, no Valido; then 1010011 -> Saida 10.
REQ-041 MAX_PASSOS=3, oscillate between positions 1 and 2 -> third move gives Saida 8, Passos 3.
REQ-042 Program index 0 to 0000111, then token 0000111 from idle -> Saida 1; Reset -> 1100000 again decodes to 1.
REQ-043 Same-cycle Reset with Limpar and Controle while at position 3 -> Saida 0, Passos 0, table at defaults.
